dma_controller: RTL and testbench

//  Single-channel 8-bit DMA controller, 16-bit address. CPU programs four setup registers.
//  On DREQ it requests the bus (HLD/HLDA) and moves data: memory-to-memory (read then write),
//  or fly-by I/O<->memory. Supports burst and cycle-steal modes. Signals completion with EOP.

---
 rtl/dma_controller.sv | 206 ++++++++++++++++++++
 tb/tb_dma_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// Single-channel 8-bit DMA controller with 16-bit addressing: memory-to-memory and
// fly-by I/O transfers, burst / cycle-steal / transparent bus modes, EOP on completion.
module dma_controller (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REGW,
    input  logic [1:0]  REGSEL,
    input  logic [15:0] Setup,
    input  logic        DREQ,
    input  logic        HLDA,
    input  logic        BG,
    input  logic        RDY,
    input  logic [7:0]  Data_in,
    output logic        HLD,
    output logic        DACK,
    output logic        MEMR,
    output logic        MEMW,
    output logic        IOR,
    output logic        IOW,
    output logic        EOP,
    output logic [15:0] Addrbus,
    output logic [7:0]  Data_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FLY   = 3'd4;
    localparam logic [2:0] S_REL   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [2:0]  after_byte_s;
    logic [7:0]  mode_r;
    logic [15:0] count_r;
    logic [15:0] src_r;
    logic [15:0] dst_r;
    logic [7:0]  temp_r;

    logic        mem2mem_s;
    logic        burst_s;
    logic        transparent_s;
    logic        byte_done_s;
    logic        read_done_s;
    logic        upd_src_s;
    logic        upd_dst_s;

    function automatic logic [15:0] addr_step(input logic [15:0] addr, input logic down);
        if (down) begin
            return addr - 16'd1;
        end else begin
            return addr + 16'd1;
        end
    endfunction

    assign mem2mem_s     = (mode_r[1:0] == 2'b10);
    assign burst_s       = (mode_r[6:5] == 2'b00) || (mode_r[6:5] == 2'b11);
    assign transparent_s = (mode_r[6:5] == 2'b10);
    assign read_done_s   = (state_r == S_READ) && HLDA && RDY;
    assign byte_done_s   = ((state_r == S_WRITE) || (state_r == S_FLY)) && HLDA && RDY;
    assign upd_src_s     = mem2mem_s || (mode_r[1:0] == 2'b01);
    assign upd_dst_s     = mem2mem_s || (mode_r[1:0] == 2'b00);

    // Where to go once a byte has completed: the zero-cycle decision after each write.
    always_comb begin
        after_byte_s = S_REL;
        if (count_r == 16'd1) begin
            after_byte_s = S_DONE;
        end else if (burst_s) begin
            if (DREQ) begin
                after_byte_s = mem2mem_s ? S_READ : S_FLY;
            end else begin
                after_byte_s = S_IDLE;
            end
        end else begin
            after_byte_s = S_REL;
        end
    end

    // Next-state logic; losing HLDA mid-byte restarts that byte from REQ.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (mode_r[7] && (count_r == 16'd0)) begin
                    next_state_s = S_DONE;
                end else if (mode_r[7] && DREQ && (mode_r[1:0] != 2'b11)) begin
                    next_state_s = S_REQ;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (HLDA && (BG || !transparent_s)) begin
                    next_state_s = mem2mem_s ? S_READ : S_FLY;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_READ: begin
                if (!HLDA) begin
                    next_state_s = S_REQ;
                end else if (RDY) begin
                    next_state_s = S_WRITE;
                end else begin
                    next_state_s = S_READ;
                end
            end
            S_WRITE, S_FLY: begin
                if (!HLDA) begin
                    next_state_s = S_REQ;
                end else if (RDY) begin
                    next_state_s = after_byte_s;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_REL:   next_state_s = DREQ ? S_REQ : S_IDLE;
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State, setup registers and address/count datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            mode_r  <= 8'h00;
            count_r <= 16'h0000;
            src_r   <= 16'h0000;
            dst_r   <= 16'h0000;
            temp_r  <= 8'h00;
        end else begin
            state_r <= next_state_s;
            if (REGW && (state_r == S_IDLE)) begin
                case (REGSEL)
                    2'b00:   mode_r  <= Setup[7:0];
                    2'b01:   count_r <= Setup;
                    2'b10:   src_r   <= Setup;
                    2'b11:   dst_r   <= Setup;
                    default: mode_r  <= mode_r;
                endcase
            end
            if (read_done_s) begin
                temp_r <= Data_in;
            end
            if (byte_done_s) begin
                count_r <= count_r - 16'd1;
                if (upd_src_s) begin
                    src_r <= addr_step(src_r, mode_r[4]);
                end
                if (upd_dst_s) begin
                    dst_r <= addr_step(dst_r, mode_r[4]);
                end
            end
            if (state_r == S_DONE) begin
                mode_r[7] <= 1'b0;
            end
        end
    end

    assign Data_out = temp_r;

    // Moore output decode from the registered state.
    always_comb begin
        HLD     = 1'b0;
        DACK    = 1'b0;
        MEMR    = 1'b0;
        MEMW    = 1'b0;
        IOR     = 1'b0;
        IOW     = 1'b0;
        EOP     = 1'b0;
        Addrbus = 16'h0000;
        case (state_r)
            S_REQ: HLD = 1'b1;
            S_READ: begin
                HLD     = 1'b1;
                MEMR    = 1'b1;
                Addrbus = src_r;
            end
            S_WRITE: begin
                HLD     = 1'b1;
                MEMW    = 1'b1;
                Addrbus = dst_r;
            end
            S_FLY: begin
                HLD  = 1'b1;
                DACK = 1'b1;
                if (mode_r[1:0] == 2'b00) begin
                    Addrbus = dst_r;
                    IOR     = 1'b1;
                    MEMW    = 1'b1;
                end else begin
                    Addrbus = src_r;
                    MEMR    = 1'b1;
                    IOW     = 1'b1;
                end
            end
            S_DONE:  EOP = 1'b1;
            default: HLD = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: directed bus-cycle traces followed by randomized transfers
// checked against a transaction-level model of addresses, data and byte counts.
module tb_dma_controller;

    logic        CLK = 1'b0;
    logic        RST, REGW, DREQ, HLDA, BG, RDY;
    logic [1:0]  REGSEL;
    logic [15:0] Setup;
    logic [7:0]  Data_in;
    logic        HLD, DACK, MEMR, MEMW, IOR, IOW, EOP;
    logic [15:0] Addrbus;
    logic [7:0]  Data_out;
    logic [6:0]  ctl;

    // {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_REQ  = 7'b1000000;
    localparam logic [6:0] C_MRD  = 7'b1010000;
    localparam logic [6:0] C_MWR  = 7'b1001000;
    localparam logic [6:0] C_IOM  = 7'b1101100;
    localparam logic [6:0] C_MIO  = 7'b1110010;
    localparam logic [6:0] C_EOP  = 7'b0000001;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_dout;

    dma_controller dut (
        .CLK(CLK), .RST(RST), .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup),
        .DREQ(DREQ), .HLDA(HLDA), .BG(BG), .RDY(RDY), .Data_in(Data_in),
        .HLD(HLD), .DACK(DACK), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW),
        .EOP(EOP), .Addrbus(Addrbus), .Data_out(Data_out)
    );

    assign ctl = {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP};

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [15:0] val);
        REGW = 1'b1;
        REGSEL = sel;
        Setup = val;
        tick();
        REGW = 1'b0;
    endtask

    task automatic program_dma(input logic [7:0] mode, input logic [15:0] cnt,
                               input logic [15:0] src, input logic [15:0] dst);
        wr_reg(2'b01, cnt);
        wr_reg(2'b10, src);
        wr_reg(2'b11, dst);
        wr_reg(2'b00, {8'h00, mode});
    endtask

    // One bus cycle: sample mid-cycle, compare strobes, address and write data.
    task automatic cyc(input string tag, input logic [6:0] exp_ctl, input logic [15:0] exp_addr);
        @(negedge CLK);
        check_val({tag, ".ctl"}, {25'd0, ctl}, {25'd0, exp_ctl});
        check_val({tag, ".addr"}, {16'd0, Addrbus}, {16'd0, exp_addr});
        check_val({tag, ".dout"}, {24'd0, Data_out}, {24'd0, exp_dout});
        tick();
    endtask

    task automatic mm_byte(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [7:0] data);
        Data_in = data;
        cyc({tag, ".rd"}, C_MRD, s);
        exp_dout = data;
        cyc({tag, ".wr"}, C_MWR, d);
    endtask

    function automatic logic [15:0] pick_addr();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 16'hFFFD + 16'($urandom_range(0, 2));
        else if (r == 1) return 16'($urandom_range(0, 2));
        else return 16'($urandom);
    endfunction

    logic [1:0]  xfer;
    logic [1:0]  tm;
    logic        dec, burst, transp, need_rel, done, prev_req, prev_go, strobe;
    logic [7:0]  mode;
    logic [15:0] cnt, es, ed, delta;
    int          bytes;

    initial begin
        RST = 1'b1; REGW = 1'b0; REGSEL = 2'b00; Setup = 16'h0000;
        DREQ = 1'b0; HLDA = 1'b0; BG = 1'b0; RDY = 1'b0; Data_in = 8'h00;
        exp_dout = 8'h00;
        tick();
        cyc("reset", C_IDLE, 16'h0000);
        RST = 1'b0;

        // Enabled with count 0: straight to EOP, even with DREQ asserted.
        DREQ = 1'b1; HLDA = 1'b1; RDY = 1'b1;
        wr_reg(2'b00, 16'h0082);
        cyc("cnt0.idle", C_IDLE, 16'h0000);
        cyc("cnt0.eop", C_EOP, 16'h0000);
        cyc("cnt0.after", C_IDLE, 16'h0000);

        // Cycle-steal mem->mem, three bytes with a released bus between them.
        program_dma(8'hA2, 16'd3, 16'h0050, 16'h0001);
        for (int b = 0; b < 3; b++) begin
            cyc("t1.gap", C_IDLE, 16'h0000);
            cyc("t1.req", C_REQ, 16'h0000);
            mm_byte("t1", 16'h0050 + 16'(b), 16'h0001 + 16'(b), 8'hC0 + 8'(b));
        end
        cyc("t1.eop", C_EOP, 16'h0000);
        cyc("t1.after", C_IDLE, 16'h0000);

        // HLDA lost during the first write: byte restarts at the same addresses.
        program_dma(8'hA2, 16'd3, 16'h0050, 16'h0001);
        cyc("t2.idle", C_IDLE, 16'h0000);
        cyc("t2.req", C_REQ, 16'h0000);
        Data_in = 8'h5A;
        cyc("t2.rd0", C_MRD, 16'h0050);
        exp_dout = 8'h5A;
        HLDA = 1'b0;
        cyc("t2.wr_abort", C_MWR, 16'h0001);
        HLDA = 1'b1;
        cyc("t2.rereq", C_REQ, 16'h0000);
        mm_byte("t2.retry", 16'h0050, 16'h0001, 8'hA5);
        for (int b = 1; b < 3; b++) begin
            cyc("t2.rel", C_IDLE, 16'h0000);
            cyc("t2.req", C_REQ, 16'h0000);
            mm_byte("t2", 16'h0050 + 16'(b), 16'h0001 + 16'(b), 8'h30 + 8'(b));
        end
        cyc("t2.eop", C_EOP, 16'h0000);

        // Burst mem->mem: HLD stays high from REQ through the last write.
        program_dma(8'h82, 16'd2, 16'h0100, 16'h0200);
        cyc("t3.idle", C_IDLE, 16'h0000);
        cyc("t3.req", C_REQ, 16'h0000);
        mm_byte("t3.b0", 16'h0100, 16'h0200, 8'h12);
        mm_byte("t3.b1", 16'h0101, 16'h0201, 8'h34);
        cyc("t3.eop", C_EOP, 16'h0000);

        // Two wait states on the read.
        program_dma(8'h82, 16'd1, 16'h0010, 16'h0020);
        cyc("t4.idle", C_IDLE, 16'h0000);
        cyc("t4.req", C_REQ, 16'h0000);
        RDY = 1'b0;
        Data_in = 8'hFF;
        cyc("t4.wait0", C_MRD, 16'h0010);
        cyc("t4.wait1", C_MRD, 16'h0010);
        RDY = 1'b1;
        mm_byte("t4", 16'h0010, 16'h0020, 8'h3C);
        cyc("t4.eop", C_EOP, 16'h0000);

        // Fly-by I/O->mem; a count write mid-transfer must be ignored.
        program_dma(8'h80, 16'd2, 16'h0000, 16'h1000);
        cyc("t5.idle", C_IDLE, 16'h0000);
        cyc("t5.req", C_REQ, 16'h0000);
        REGW = 1'b1; REGSEL = 2'b01; Setup = 16'h0005;
        cyc("t5.fly0", C_IOM, 16'h1000);
        REGW = 1'b0;
        cyc("t5.fly1", C_IOM, 16'h1001);
        cyc("t5.eop", C_EOP, 16'h0000);
        cyc("t5.after", C_IDLE, 16'h0000);

        // Fly-by mem->I/O decrementing through the 0x0000 -> 0xFFFF wrap.
        program_dma(8'h91, 16'd3, 16'h0001, 16'h0000);
        cyc("t5b.idle", C_IDLE, 16'h0000);
        cyc("t5b.req", C_REQ, 16'h0000);
        cyc("t5b.fly0", C_MIO, 16'h0001);
        cyc("t5b.fly1", C_MIO, 16'h0000);
        cyc("t5b.fly2", C_MIO, 16'hFFFF);
        cyc("t5b.eop", C_EOP, 16'h0000);

        // Reset mid-transfer: everything clears, no EOP afterwards.
        program_dma(8'hA2, 16'd3, 16'h0300, 16'h0400);
        cyc("t6.idle", C_IDLE, 16'h0000);
        cyc("t6.req", C_REQ, 16'h0000);
        Data_in = 8'h77;
        cyc("t6.rd", C_MRD, 16'h0300);
        exp_dout = 8'h77;
        RST = 1'b1;
        cyc("t6.wr", C_MWR, 16'h0400);
        RST = 1'b0;
        exp_dout = 8'h00;
        for (int i = 0; i < 4; i++) cyc("t6.post_rst", C_IDLE, 16'h0000);

        // Randomized transfers against a transaction-level model.
        for (int it = 0; it < 40; it++) begin
            xfer = 2'($urandom_range(0, 2));
            tm = 2'($urandom_range(0, 3));
            dec = 1'($urandom_range(0, 1));
            mode = {1'b1, tm, dec, 2'b00, xfer};
            cnt = 16'($urandom_range(0, 6));
            es = pick_addr();
            ed = pick_addr();
            burst = (tm == 2'd0) || (tm == 2'd3);
            transp = (tm == 2'd2);
            delta = dec ? 16'hFFFF : 16'h0001;
            DREQ = 1'b0;
            program_dma(mode, cnt, es, ed);
            bytes = 0; need_rel = 1'b0; done = 1'b0; prev_req = 1'b0; prev_go = 1'b0;
            for (int c = 0; c < 600 && !done; c++) begin
                DREQ = ($urandom_range(0, 9) < 8);
                HLDA = ($urandom_range(0, 9) < 9);
                RDY = ($urandom_range(0, 3) != 0);
                BG = ($urandom_range(0, 2) != 0);
                Data_in = 8'($urandom);
                @(negedge CLK);
                strobe = MEMR | MEMW | IOR | IOW;
                check_val("rnd.dout", {24'd0, Data_out}, {24'd0, exp_dout});
                if (!HLD) need_rel = 1'b0;
                if (EOP) begin
                    check_val("rnd.eop_ctl", {25'd0, ctl}, {25'd0, C_EOP});
                    check_val("rnd.bytes", bytes, {16'd0, cnt});
                    done = 1'b1;
                end else if (strobe) begin
                    check_val("rnd.extra_byte", {31'd0, bytes < int'(cnt)}, 32'd1);
                    check_val("rnd.rel_gap", {31'd0, need_rel}, 32'd0);
                    if (prev_req) check_val("rnd.grant", {31'd0, prev_go}, 32'd1);
                    if (xfer == 2'd2 && MEMR) begin
                        check_val("rnd.mm_rd_ctl", {25'd0, ctl}, {25'd0, C_MRD});
                        check_val("rnd.mm_rd_addr", {16'd0, Addrbus}, {16'd0, es});
                        if (HLDA && RDY) exp_dout = Data_in;
                    end else begin
                        check_val("rnd.ctl", {25'd0, ctl},
                                  {25'd0, (xfer == 2'd2) ? C_MWR : (xfer == 2'd0) ? C_IOM : C_MIO});
                        check_val("rnd.addr", {16'd0, Addrbus}, {16'd0, (xfer == 2'd1) ? es : ed});
                        if (HLDA && RDY) begin
                            if (xfer != 2'd0) es = es + delta;
                            if (xfer != 2'd1) ed = ed + delta;
                            bytes++;
                            need_rel = !burst;
                        end
                    end
                end else begin
                    check_val("rnd.quiet", {25'd0, ctl & 7'b0111111}, 32'd0);
                    check_val("rnd.quiet_addr", {16'd0, Addrbus}, 32'd0);
                end
                prev_req = (ctl == C_REQ);
                prev_go = HLDA && (BG || !transp);
                tick();
            end
            if (!done) check_val("rnd.timeout", {31'd0, done}, 32'd1);
            DREQ = 1'b1;
            cyc("rnd.post0", C_IDLE, 16'h0000);
            cyc("rnd.post1", C_IDLE, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
